// File: rtl/hazard_forward_unit.sv
// Data-hazard and forwarding unit: shadows the EX/MEM/WB destinations, drives the operand
// forwarding selects, and inserts a single-cycle load-use stall.
module hazard_forward_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A_S_ID,
    input  logic             B_S_ID,
    input  logic             D_S_ID,
    input  logic             ID_NOP_ID,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic [4:0]       RD_ID,
    input  logic             RF_LE_ID,
    input  logic             L_ID,
    input  logic             FLUSH_ID,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic [1:0]       FWD_D,
    output logic             LE_PC,
    output logic             LE_IF_ID,
    output logic             NOP_EX,
    output logic [CNT_W-1:0] STALL_CNT
);

    typedef struct packed {
        logic       v;
        logic       we;
        logic       ld;
        logic [4:0] rd;
    } entry_t;

    entry_t     ex_q, ex_d;
    entry_t     mem_q;
    // Nothing reads the load flag once an instruction leaves MEM, so WB keeps only V/WE/RD.
    logic       wb_v_q, wb_we_q;
    logic [4:0] wb_rd_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic kill;
    logic load_use;
    logic hit_a, hit_b, hit_d;

    function automatic logic stage_match(input logic v, input logic we, input logic [4:0] rd,
                                         input logic [4:0] r);
        return v & we & (rd == r) & (r != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] r,
                                           input entry_t ex, input entry_t mem,
                                           input logic wv, input logic wwe,
                                           input logic [4:0] wrd);
        if (!used)                                return 2'b00;
        else if (stage_match(ex.v, ex.we, ex.rd, r))    return 2'b01;
        else if (stage_match(mem.v, mem.we, mem.rd, r)) return 2'b10;
        else if (stage_match(wv, wwe, wrd, r))          return 2'b11;
        else                                            return 2'b00;
    endfunction

    always_comb begin
        kill  = ID_NOP_ID | FLUSH_ID;

        FWD_A = fwd_sel(A_S_ID & ~kill, RS1_ID, ex_q, mem_q, wb_v_q, wb_we_q, wb_rd_q);
        FWD_B = fwd_sel(B_S_ID & ~kill, RS2_ID, ex_q, mem_q, wb_v_q, wb_we_q, wb_rd_q);
        FWD_D = fwd_sel(D_S_ID & ~kill, RD_ID,  ex_q, mem_q, wb_v_q, wb_we_q, wb_rd_q);

        hit_a = A_S_ID & stage_match(ex_q.v, ex_q.we, ex_q.rd, RS1_ID);
        hit_b = B_S_ID & stage_match(ex_q.v, ex_q.we, ex_q.rd, RS2_ID);
        hit_d = D_S_ID & stage_match(ex_q.v, ex_q.we, ex_q.rd, RD_ID);

        load_use = ex_q.ld & (hit_a | hit_b | hit_d) & ~kill;

        // A flush also bubbles EX but must not freeze fetch or count as a stall.
        LE_PC    = ~load_use;
        LE_IF_ID = ~load_use;
        NOP_EX   = load_use | FLUSH_ID;

        if (kill || NOP_EX) begin
            ex_d = '0;
        end else begin
            ex_d = '{v: 1'b1, we: RF_LE_ID, ld: L_ID, rd: RD_ID};
        end

        cnt_d = cnt_q;
        if (load_use && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_v_q  <= 1'b0;
            wb_we_q <= 1'b0;
            wb_rd_q <= 5'd0;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_v_q  <= mem_q.v;
            wb_we_q <= mem_q.we;
            wb_rd_q <= mem_q.rd;
            cnt_q   <= cnt_d;
        end
    end

    assign STALL_CNT = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit with hand-computed expectations.
module tb_hazard_forward_unit;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             A_S_ID, B_S_ID, D_S_ID, ID_NOP_ID;
    logic [4:0]       RS1_ID, RS2_ID, RD_ID;
    logic             RF_LE_ID, L_ID, FLUSH_ID;
    logic [1:0]       FWD_A, FWD_B, FWD_D;
    logic             LE_PC, LE_IF_ID, NOP_EX;
    logic [CNT_W-1:0] STALL_CNT;

    int n_vec = 0;
    int n_err = 0;

    hazard_forward_unit #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A_S_ID    (A_S_ID),
        .B_S_ID    (B_S_ID),
        .D_S_ID    (D_S_ID),
        .ID_NOP_ID (ID_NOP_ID),
        .RS1_ID    (RS1_ID),
        .RS2_ID    (RS2_ID),
        .RD_ID     (RD_ID),
        .RF_LE_ID  (RF_LE_ID),
        .L_ID      (L_ID),
        .FLUSH_ID  (FLUSH_ID),
        .FWD_A     (FWD_A),
        .FWD_B     (FWD_B),
        .FWD_D     (FWD_D),
        .LE_PC     (LE_PC),
        .LE_IF_ID  (LE_IF_ID),
        .NOP_EX    (NOP_EX),
        .STALL_CNT (STALL_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one ID instruction at the falling edge; outputs settle 1 ns later.
    task automatic issue(input logic a, input logic b, input logic d, input logic nop,
                         input logic flush, input logic le, input logic ld,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        @(negedge clk);
        A_S_ID = a; B_S_ID = b; D_S_ID = d; ID_NOP_ID = nop; FLUSH_ID = flush;
        RF_LE_ID = le; L_ID = ld; RS1_ID = rs1; RS2_ID = rs2; RD_ID = rd;
        #1;
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic dist_test(input int gap, input logic [1:0] exp_sel, input string tag);
        bubbles(4);
        issue(0, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd5);
        bubbles(gap);
        issue(1, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0, 5'd0);
        check(tag, FWD_A, exp_sel);
        check({tag, "_nostall"}, NOP_EX, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        A_S_ID = 0; B_S_ID = 0; D_S_ID = 0; ID_NOP_ID = 1; FLUSH_ID = 0;
        RF_LE_ID = 0; L_ID = 0; RS1_ID = 0; RS2_ID = 0; RD_ID = 0;
        #2;
        check("rst_fwd_a", FWD_A, 2'b00);
        check("rst_fwd_b", FWD_B, 2'b00);
        check("rst_fwd_d", FWD_D, 2'b00);
        check("rst_le_pc", LE_PC, 1'b1);
        check("rst_le_ifid", LE_IF_ID, 1'b1);
        check("rst_nop_ex", NOP_EX, 1'b0);
        check("rst_cnt", STALL_CNT, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bubbles(2);
        check("idle_nop_ex", NOP_EX, 1'b0);
        check("idle_cnt", STALL_CNT, 0);

        // Producer-to-consumer distance selects EX, MEM, WB, then register file.
        dist_test(0, 2'b01, "dist0");
        dist_test(1, 2'b10, "dist1");
        dist_test(2, 2'b11, "dist2");
        dist_test(3, 2'b00, "dist3");

        // Load r8 followed by a store reading r8 on B: one stall, then forward from MEM.
        bubbles(4);
        issue(0, 0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd8);
        issue(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd8, 5'd9);
        check("lu_nop_ex", NOP_EX, 1'b1);
        check("lu_le_pc", LE_PC, 1'b0);
        check("lu_le_ifid", LE_IF_ID, 1'b0);
        check("lu_fwd_b", FWD_B, 2'b01);
        check("lu_fwd_d", FWD_D, 2'b00);
        issue(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd8, 5'd9);
        check("lu2_fwd_b", FWD_B, 2'b10);
        check("lu2_nop_ex", NOP_EX, 1'b0);
        check("lu2_le_pc", LE_PC, 1'b1);
        check("lu2_cnt", STALL_CNT, 1);
        issue(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        check("lu3_cnt", STALL_CNT, 1);

        // %g0 as a load destination: no forwarding, no stall.
        bubbles(4);
        issue(0, 0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
        issue(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        check("r0_fwd_a", FWD_A, 2'b00);
        check("r0_nop_ex", NOP_EX, 1'b0);
        check("r0_le_pc", LE_PC, 1'b1);

        // Flush coinciding with a load-use hazard; the flushed instruction would write r8.
        bubbles(4);
        issue(0, 0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd8);
        issue(0, 1, 0, 0, 1, 1, 0, 5'd0, 5'd8, 5'd8);
        check("fl_nop_ex", NOP_EX, 1'b1);
        check("fl_le_pc", LE_PC, 1'b1);
        check("fl_le_ifid", LE_IF_ID, 1'b1);
        check("fl_fwd_b", FWD_B, 2'b00);
        issue(1, 0, 0, 0, 0, 0, 0, 5'd8, 5'd0, 5'd0);
        check("fl2_fwd_a", FWD_A, 2'b10);
        check("fl2_nop_ex", NOP_EX, 1'b0);
        check("fl2_cnt", STALL_CNT, 1);

        // r3 in EX, MEM and WB: EX has priority on all three operands.
        bubbles(4);
        issue(0, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd3);
        issue(0, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd3);
        issue(0, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd3);
        issue(1, 1, 1, 0, 0, 0, 0, 5'd3, 5'd3, 5'd3);
        check("tri_fwd_a", FWD_A, 2'b01);
        check("tri_fwd_b", FWD_B, 2'b01);
        check("tri_fwd_d", FWD_D, 2'b01);
        check("tri_cnt", STALL_CNT, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_fwd_a", FWD_A, 2'b00);
        check("mrst_fwd_b", FWD_B, 2'b00);
        check("mrst_fwd_d", FWD_D, 2'b00);
        check("mrst_le_pc", LE_PC, 1'b1);
        check("mrst_cnt", STALL_CNT, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bubbles(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
